// File: rtl/alu_defs.sv
// rtl/alu_defs.sv - ALUControl codes and response-register state shared by the ALU and arbiter
package alu_defs;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    typedef enum logic {
        RSP_EMPTY = 1'b0,
        RSP_FULL  = 1'b1
    } rsp_state_t;

endpackage

// File: rtl/MIPS_ALU.sv
// rtl/MIPS_ALU.sv - combinational MIPS ALU; SLT is an unsigned compare, unknown codes yield 0
module MIPS_ALU
    import alu_defs::*;
(
    input  logic [3:0]  ALUControl,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [31:0] ALUResult,
    output logic        Zero
);

    always_comb begin
        ALUResult = 32'd0;
        case (ALUControl)
            ALU_AND: ALUResult = A & B;
            ALU_OR:  ALUResult = A | B;
            ALU_ADD: ALUResult = A + B;
            ALU_SUB: ALUResult = A - B;
            ALU_SLT: ALUResult = (A < B) ? 32'd1 : 32'd0;
            default: ALUResult = 32'd0;
        endcase
    end

    assign Zero = (ALUResult == 32'd0);

endmodule

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin grant: first request at or above ptr, wrapping
module rr_arbiter #(
    parameter int NREQ = 2,
    parameter int ID_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [ID_W-1:0] ptr,
    output logic [NREQ-1:0] grant
);

    logic [ID_W-1:0] idx;

    // Walk offsets from farthest to nearest so the closest request to ptr overwrites the rest.
    always_comb begin
        grant = '0;
        idx   = '0;
        for (int off = NREQ - 1; off >= 0; off--) begin
            idx = ID_W'((int'(ptr) + off) % NREQ);
            if (req[idx]) begin
                grant      = '0;
                grant[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin sharing of one MIPS_ALU among NREQ requesters, registered tagged response
module alu_arbiter
    import alu_defs::*;
#(
    parameter int NREQ   = 2,
    parameter int DATA_W = 32,
    parameter int ID_W   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [NREQ*DATA_W-1:0] req_a,
    input  logic [NREQ*DATA_W-1:0] req_b,
    input  logic [NREQ*4-1:0]      req_ctrl,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [DATA_W-1:0]      rsp_data,
    output logic                   rsp_zero,
    output logic [ID_W-1:0]        rsp_id
);

    rsp_state_t        state_q, state_d;
    logic [ID_W-1:0]   ptr_q;
    logic [ID_W-1:0]   gidx;
    logic [NREQ-1:0]   grant;
    logic              can_accept;
    logic              accept;
    logic [DATA_W-1:0] alu_a, alu_b, alu_y;
    logic [3:0]        alu_ctrl;
    logic              alu_zero;

    rr_arbiter #(
        .NREQ (NREQ),
        .ID_W (ID_W)
    ) u_rr_arbiter (
        .req   (req_valid),
        .ptr   (ptr_q),
        .grant (grant)
    );

    always_comb begin
        gidx     = '0;
        alu_a    = '0;
        alu_b    = '0;
        alu_ctrl = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                gidx     = ID_W'(i);
                alu_a    = req_a[i*DATA_W +: DATA_W];
                alu_b    = req_b[i*DATA_W +: DATA_W];
                alu_ctrl = req_ctrl[i*4 +: 4];
            end
        end
    end

    MIPS_ALU u_alu (
        .ALUControl (alu_ctrl),
        .A          (alu_a),
        .B          (alu_b),
        .ALUResult  (alu_y),
        .Zero       (alu_zero)
    );

    // A full register can take a new result in the same edge it is drained.
    assign can_accept = (state_q == RSP_EMPTY) || rsp_ready;
    assign req_ready  = rst_n ? (grant & {NREQ{can_accept}}) : '0;
    assign accept     = |req_ready;
    assign rsp_valid  = (state_q == RSP_FULL);

    always_comb begin
        state_d = state_q;
        case (state_q)
            RSP_EMPTY: if (accept) state_d = RSP_FULL;
            RSP_FULL:  if (!accept && rsp_ready) state_d = RSP_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= RSP_EMPTY;
            ptr_q    <= '0;
            rsp_data <= '0;
            rsp_zero <= 1'b0;
            rsp_id   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                rsp_data <= alu_y;
                rsp_zero <= alu_zero;
                rsp_id   <= gidx;
                ptr_q    <= (gidx == ID_W'(NREQ - 1)) ? '0 : gidx + ID_W'(1);
            end
        end
    end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single combinational MIPS_ALU between NREQ independent requesters, e.g. the main datapath, a branch-compare unit and a debug port.
- Round-robin arbitration with a valid/ready handshake on each request port.
- One registered response port with a requester tag.
- Sustains one operation per cycle when the response side never stalls.

Parameters:
- NREQ, 2, number of requesters (2..8).
- DATA_W, 32, operand and result width; fixed at 32 to match MIPS_ALU.
- ID_W, $clog2(NREQ) (minimum 1), width of the requester tag.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  NREQ  bit i = requester i presents an operation.
- req_ready  out  NREQ  bit i = requester i's operation is accepted this cycle.
- req_a  in  NREQ*DATA_W  operand A; requester i occupies bits [i*DATA_W +: DATA_W].
- req_b  in  NREQ*DATA_W  operand B, packed the same way.
- req_ctrl  in  NREQ*4  ALUControl code; requester i occupies bits [i*4 +: 4].
- rsp_valid  out  1  the response register holds a result.
- rsp_ready  in  1  the consumer takes the result this cycle.
- rsp_data  out  DATA_W  registered ALU result.
- rsp_zero  out  1  registered Zero flag.
- rsp_id  out  ID_W  index of the requester that owns the result.

Behaviour:
- Reset (asynchronous, on rst_n low, also mid-operation):
  - rsp_valid=0, rsp_data=0, rsp_zero=0, rsp_id=0.
  - Round-robin pointer=0, so requester 0 has highest priority.
  - Any in-flight result is discarded.
  - req_ready is 0 while rst_n is low.
- Response register FSM, 2 states:
  - EMPTY (rsp_valid=0), FULL (rsp_valid=1).
  - can_accept = EMPTY | (FULL & rsp_ready).
- Arbitration (combinational):
  - grant = first asserted req_valid bit searching from pointer upward, wrapping modulo NREQ.
  - req_ready[i] = grant[i] & can_accept.
  - At most one req_ready bit is high. req_ready never asserts for a requester whose req_valid is low.
- Datapath: the granted requester's a/b/ctrl are muxed into one MIPS_ALU instance.
- Accept (any req_ready high) at the clock edge:
  - rsp_data <= ALU result, rsp_zero <= ALU Zero, rsp_id <= granted index.
  - State <= FULL.
  - Pointer <= (granted index + 1) mod NREQ.
- No accept, FULL & rsp_ready: state <= EMPTY. rsp_data, rsp_zero and rsp_id hold their last values.
- No accept, FULL & !rsp_ready: everything holds (stall); all req_ready=0.
- Simultaneous drain and accept in one cycle: the new result replaces the old with no bubble, so throughput is 1 per cycle.
- Latency: result appears on rsp_* exactly 1 cycle after acceptance.
- Pointer holds when nothing is accepted.
- ALU semantics (must match MIPS_ALU exactly):
  - 0000 AND, 0001 OR, 0010 ADD (wraps mod 2^32), 0110 SUB (wraps mod 2^32).
  - 0111 SLT is an unsigned compare: result 1 or 0.
  - Any other code: result 0, Zero=1.
- Requester rule: a requester keeps valid/a/b/ctrl stable until its ready is seen. The block does not check this.
- Fairness: with all NREQ requesters continuously valid and rsp_ready=1, each is granted exactly once in every NREQ consecutive cycles.

Decomposition:
- Shared package/include (alu_defs): ALUControl localparams ALU_AND=4'b0000, ALU_OR=4'b0001, ALU_ADD=4'b0010, ALU_SUB=4'b0110, ALU_SLT=4'b0111. MIPS_ALU and the datapath control decoder also use these.
- Sub-module rr_arbiter(NREQ): inputs req, pointer; output one-hot grant. Purely combinational.
- Top level holds the pointer register, the response register and the FSM.
- Reuse the existing MIPS_ALU unchanged; do not duplicate ALU logic.

Test Plan:
1. Reset mid-stream: rst_n low while FULL with rsp_data=7 -> rsp_valid=0, rsp_data=0, rsp_id=0 immediately, before any clock edge. After release, req 0 and req 1 both valid -> req 0 granted first.
2. Single op: req1 a=5, b=5, ctrl=0110 with rsp_ready=1 -> req_ready=2'b10 that cycle. Next cycle rsp_valid=1, rsp_data=0, rsp_zero=1, rsp_id=1.
3. Round-robin: NREQ=2, both valid continuously, rsp_ready=1, ops ADD 3+4 / SLT 2<9 -> rsp_id alternates 0,1,0,1 and rsp_data alternates 7,1 with no idle cycle.
4. Backpressure: FULL with rsp_ready=0 for 3 cycles -> req_ready=0 and rsp_* stable. Raise rsp_ready with req0 valid -> drain and accept in the same edge, no bubble.
5. Arithmetic edges: ADD 0xFFFFFFFF+1 -> 0, zero=1. SLT 0x80000000 < 1 -> 0 (unsigned compare). ctrl=1111 -> 0, zero=1. AND 0xF0F0F0F0 & 0x0FF00FF0 -> 0x00F000F0, zero=0.
6. Idle handling: no req_valid for 4 cycles with rsp_ready=1 -> rsp_valid drops after drain, pointer unchanged. Then req1 alone valid -> granted immediately.
